dpe_ingress_pkt_fifo: RTL and testbench
=======================================

Name: dpe_ingress_pkt_fifo

Overview:
- Per-port store-and-forward packet buffer between an Ethernet MAC RX stream and one `from_eth_N` input of the DPE multiplexer. The top level instantiates one per Ethernet port.
- Accepts AXI-Stream beats from the MAC at line rate and never back-pressures it.
- Drops frames that are errored, oversized, or arrive while the buffer is full.
- Presents only complete, good frames downstream, so the multiplexer never stalls mid-packet on a starved source.

Parameters:
- DATA_W, 64: stream data width in bits; multiple of 8.
- DEPTH, 512: buffer depth in beats; power of 2, at least 16.
- PTR_W, $clog2(DEPTH): pointer width; derived, not overridden.

Ports:
- clk  in  1  single clock domain for the block.
- rst  in  1  synchronous, active-low reset.
- s_tdata  in  DATA_W  ingress data.
- s_tkeep  in  DATA_W/8  ingress byte enables.
- s_tlast  in  1  ingress end-of-frame.
- s_tuser  in  1  MAC frame error; sampled only with s_tlast.
- s_tvalid  in  1  ingress beat valid.
- s_tready  out  1  ingress ready.
- m_tdata  out  DATA_W  egress data.
- m_tkeep  out  DATA_W/8  egress byte enables.
- m_tlast  out  1  egress end-of-frame.
- m_tvalid  out  1  egress valid.
- m_tready  in  1  egress ready.
- pkt_avail  out  1  at least one committed frame is held.
- drop_pulse  out  1  one-cycle pulse per dropped frame.

Behaviour:
- Reset (rst=0 at a clk edge):
  - All pointers and pkt_cnt go to 0; state goes to IDLE.
  - s_tready, m_tvalid, pkt_avail and drop_pulse are 0.
  - s_tready rises to 1 on the first cycle after reset releases and stays 1.
- Reset mid-frame discards the partial frame and all stored frames.
- Storage: RAM of DEPTH words, each word {tlast, tkeep, tdata}. Pointers are PTR_W bits and wrap modulo DEPTH.
- Write side uses wr_ptr (speculative) and cmt_ptr (committed). Full means wr_ptr+1 == rd_ptr, where rd_ptr is the RAM read pointer.
- Write FSM:
  - IDLE/WRITE, beat accepted and not full: write the word at wr_ptr, then wr_ptr+1. Non-last beat moves to WRITE.
  - tlast with s_tuser=0: cmt_ptr <= wr_ptr+1 and pkt_cnt+1; go to IDLE.
  - tlast with s_tuser=1: wr_ptr <= cmt_ptr, drop_pulse=1; go to IDLE.
  - Beat arrives while full:
    - Do not write the beat.
    - Non-last beat: go to DROP.
    - Last beat: rewind wr_ptr to cmt_ptr, pulse drop_pulse, stay IDLE.
  - DROP: discard beats until tlast. On tlast, wr_ptr <= cmt_ptr, drop_pulse=1; go to IDLE.
  - A frame longer than DEPTH-1 beats is therefore always dropped.
- Read side:
  - The readable region is [rd_ptr, cmt_ptr); uncommitted data is never read.
  - RAM read is registered and feeds a 2-entry output skid buffer.
  - Sustains 1 beat/clk with m_tready held at 1.
  - m_tvalid first asserts 2 cycles after the commit cycle when the buffer was empty.
  - m_* are held stable while m_tvalid=1 and m_tready=0.
- pkt_cnt:
  - Decrements on the m_tlast handshake.
  - Commit and drain on the same cycle leave pkt_cnt unchanged.
  - pkt_avail = (pkt_cnt != 0), registered.
- A simultaneous read-pointer advance and last-slot write uses the pre-advance rd_ptr for the full check: conservative, so no overwrite is possible.

Optional Feature:
- Macro: DPE_INGRESS_FIFO_STATS_EN.
- When defined, three output ports are added, each 32-bit, saturating at 32'hFFFF_FFFF, cleared by reset:
  - rx_pkt_cnt: committed frames.
  - drop_err_cnt: frames dropped on s_tuser.
  - drop_full_cnt: frames dropped on full or oversize.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- dpe_pkg gains:
  - DPE_DATA_W, DPE_KEEP_W.
  - typedef dpe_beat_t {tlast, tkeep, tdata}.
  - enum ing_fifo_state_e {IDLE, WRITE, DROP}.
- One sub-module: dpe_sdp_ram. Simple dual-port, 1W/1R, registered read, parameterised width and depth, inferable as block RAM.
- Pointer logic, FSM and skid buffer stay in dpe_ingress_pkt_fifo.

Test Plan:
- Single good frame: 4 beats, s_tuser=0, m_tready=1 → 4 beats out in order with tkeep preserved; m_tvalid 2 cycles after commit; pkt_avail high then low.
- Errored frame then good frame: 3 beats with s_tuser=1 on last, then a 2-beat good frame → one drop_pulse; only the 2-beat frame emerges; pointers rewound.
- Fill to full: DEPTH=16, m_tready=0, stream 20-beat frame → frame dropped with one drop_pulse on its tlast; a following 5-beat frame is stored and emerges intact once m_tready=1.
- Back-pressure: 3 stored 8-beat frames, m_tready toggling 1010 → no beat lost or duplicated; m_* stable while stalled; pkt_cnt reaches 0 after 24 beats.
- Wrap and concurrency: continuous 1-beat and 7-beat frames across pointer wrap with m_tready=1 → throughput 1 beat/clk; commit and drain on the same cycle keep pkt_cnt correct.
- Reset mid-frame: assert rst during beat 2 of 6 with one stored frame → m_tvalid=0 next cycle; after release, the new frame passes and the old data never appears.

Source files
------------

// File: rtl/dpe_pkg.sv
// Shared widths, beat type and write-FSM state encoding for the DPE datapath.
package dpe_pkg;

  localparam int unsigned DPE_DATA_W = 64;
  localparam int unsigned DPE_KEEP_W = DPE_DATA_W / 8;

  typedef struct packed {
    logic                  tlast;
    logic [DPE_KEEP_W-1:0] tkeep;
    logic [DPE_DATA_W-1:0] tdata;
  } dpe_beat_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DROP
  } ing_fifo_state_e;

  function automatic logic [31:0] sat_inc32(logic [31:0] val, logic en);
    return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
  endfunction

endpackage

// File: rtl/dpe_sdp_ram.sv
// Simple dual-port RAM, one write and one registered read port; maps onto block RAM.
module dpe_sdp_ram #(
  parameter int unsigned Width = 73,
  parameter int unsigned Depth = 512,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dpe_ingress_pkt_fifo.sv
// Per-port store-and-forward ingress FIFO: drops errored/oversized/overflowing frames and
// releases only committed frames. Build macro DPE_INGRESS_FIFO_STATS_EN adds stats counters.
module dpe_ingress_pkt_fifo
  import dpe_pkg::*;
#(
  parameter int unsigned DATA_W = DPE_DATA_W,
  parameter int unsigned DEPTH  = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic                s_tlast,
  input  logic                s_tuser,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tlast,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                pkt_avail,
  output logic                drop_pulse
`ifdef DPE_INGRESS_FIFO_STATS_EN
  ,
  output logic [31:0]         rx_pkt_cnt,
  output logic [31:0]         drop_err_cnt,
  output logic [31:0]         drop_full_cnt
`endif
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);
  localparam logic [PTR_W:0]   CntOne = (PTR_W + 1)'(1);

  typedef struct packed {
    logic              tlast;
    logic [KEEP_W-1:0] tkeep;
    logic [DATA_W-1:0] tdata;
  } beat_t;

  ing_fifo_state_e state_q, state_d;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_inc;
  logic [PTR_W:0]   pkt_cnt_q, pkt_cnt_d;

  logic s_tready_q;
  logic pkt_avail_q, pkt_avail_d;
  logic drop_pulse_q, drop_pulse_d;

  logic beat_ok, full;
  logic ram_we, commit, drop_err, drop_full;

  beat_t wr_beat, ram_rdata;
  logic  rd_en, ram_vld_q, pop, drain;
  logic [2:0] rd_budget;
  logic [1:0] skid_cnt_q, skid_cnt_d, skid_fill;
  beat_t head_q, head_d, tail_q, tail_d;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  assign beat_ok    = s_tvalid & s_tready_q;
  assign wr_ptr_inc = wr_ptr_q + PtrOne;
  // rd_ptr_q is the pre-advance value, so a same-cycle read can only make this pessimistic.
  assign full       = (wr_ptr_inc == rd_ptr_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (beat_ok) begin
      unique case (state_q)
        IDLE, WRITE: begin
          if (s_tlast) begin
            state_d = IDLE;
          end else if (full) begin
            state_d = DROP;
          end else begin
            state_d = WRITE;
          end
        end
        DROP: begin
          if (s_tlast) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    commit    = 1'b0;
    drop_err  = 1'b0;
    drop_full = 1'b0;
    if (beat_ok) begin
      unique case (state_q)
        IDLE, WRITE: begin
          if (full) begin
            drop_full = s_tlast;
          end else begin
            ram_we   = 1'b1;
            commit   = s_tlast & ~s_tuser;
            drop_err = s_tlast & s_tuser;
          end
        end
        DROP:    drop_full = s_tlast;
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    if (ram_we) begin
      wr_ptr_d = wr_ptr_inc;
    end
    if (commit) begin
      cmt_ptr_d = wr_ptr_inc;
    end
    if (drop_err || drop_full) begin
      wr_ptr_d = cmt_ptr_q;
    end
  end

  assign wr_beat.tlast = s_tlast;
  assign wr_beat.tkeep = s_tkeep;
  assign wr_beat.tdata = s_tdata;

  dpe_sdp_ram #(
    .Width ($bits(beat_t)),
    .Depth (DEPTH),
    .AddrW (PTR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_beat),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Read side: registered RAM read into a 2-entry skid buffer
  // ---------------------------------------------------------------------------
  assign pop   = (skid_cnt_q != 2'd0) & m_tready;
  assign drain = pop & head_q.tlast;

  // Skid entries plus the beat in flight from the RAM must never exceed two.
  assign rd_budget = {1'b0, skid_cnt_q} + {2'b00, ram_vld_q} - {2'b00, pop};
  assign rd_en     = (rd_ptr_q != cmt_ptr_q) && (rd_budget < 3'd2);
  assign rd_ptr_d  = rd_en ? rd_ptr_q + PtrOne : rd_ptr_q;
  assign skid_fill = skid_cnt_q - {1'b0, pop};

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    skid_cnt_d = skid_cnt_q + {1'b0, ram_vld_q} - {1'b0, pop};
    if (pop) begin
      head_d = tail_q;
    end
    if (ram_vld_q) begin
      if (skid_fill == 2'd0) begin
        head_d = ram_rdata;
      end else begin
        tail_d = ram_rdata;
      end
    end
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    case ({commit, drain})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CntOne;
      2'b01:   pkt_cnt_d = pkt_cnt_q - CntOne;
      default: ;
    endcase
    pkt_avail_d  = (pkt_cnt_d != '0);
    drop_pulse_d = drop_err | drop_full;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      cmt_ptr_q    <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      s_tready_q   <= 1'b0;
      pkt_avail_q  <= 1'b0;
      drop_pulse_q <= 1'b0;
      ram_vld_q    <= 1'b0;
      skid_cnt_q   <= 2'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      cmt_ptr_q    <= cmt_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      s_tready_q   <= 1'b1;
      pkt_avail_q  <= pkt_avail_d;
      drop_pulse_q <= drop_pulse_d;
      ram_vld_q    <= rd_en;
      skid_cnt_q   <= skid_cnt_d;
    end
  end

  // Payload registers carry no reset; skid_cnt_q qualifies them.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign s_tready   = s_tready_q;
  assign m_tvalid   = (skid_cnt_q != 2'd0);
  assign m_tdata    = head_q.tdata;
  assign m_tkeep    = head_q.tkeep;
  assign m_tlast    = head_q.tlast;
  assign pkt_avail  = pkt_avail_q;
  assign drop_pulse = drop_pulse_q;

`ifdef DPE_INGRESS_FIFO_STATS_EN
  logic [31:0] rx_pkt_cnt_q, rx_pkt_cnt_d;
  logic [31:0] drop_err_cnt_q, drop_err_cnt_d;
  logic [31:0] drop_full_cnt_q, drop_full_cnt_d;

  always_comb begin
    rx_pkt_cnt_d    = sat_inc32(rx_pkt_cnt_q, commit);
    drop_err_cnt_d  = sat_inc32(drop_err_cnt_q, drop_err);
    drop_full_cnt_d = sat_inc32(drop_full_cnt_q, drop_full);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_pkt_cnt_q    <= '0;
      drop_err_cnt_q  <= '0;
      drop_full_cnt_q <= '0;
    end else begin
      rx_pkt_cnt_q    <= rx_pkt_cnt_d;
      drop_err_cnt_q  <= drop_err_cnt_d;
      drop_full_cnt_q <= drop_full_cnt_d;
    end
  end

  assign rx_pkt_cnt    = rx_pkt_cnt_q;
  assign drop_err_cnt  = drop_err_cnt_q;
  assign drop_full_cnt = drop_full_cnt_q;
`endif

endmodule

// File: tb/tb_dpe_ingress_pkt_fifo.sv
// Self-checking bench for dpe_ingress_pkt_fifo: frame-level queue model plus directed tests.
module tb_dpe_ingress_pkt_fifo;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned KEEP_W  = DATA_W / 8;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned LastBit = KEEP_W + DATA_W;

  typedef logic [LastBit:0] beat_t;  // {tlast, tkeep, tdata}

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] s_tdata;
  logic [KEEP_W-1:0] s_tkeep;
  logic              s_tlast;
  logic              s_tuser;
  logic              s_tvalid;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic [KEEP_W-1:0] m_tkeep;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic              pkt_avail;
  logic              drop_pulse;

  dpe_ingress_pkt_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_tdata    (s_tdata),
    .s_tkeep    (s_tkeep),
    .s_tlast    (s_tlast),
    .s_tuser    (s_tuser),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tkeep    (m_tkeep),
    .m_tlast    (m_tlast),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .pkt_avail  (pkt_avail),
    .drop_pulse (drop_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Model state: frames the spec says must emerge, in order.
  beat_t exp_q[$];
  beat_t cur_q[$];
  int    pend_cnt    = 0;
  bit    frame_good  = 1'b1;
  bit    drop_pend   = 1'b0;
  bit    rst_seen    = 1'b0;
  bit    prev_stall  = 1'b0;
  bit    mid_frame   = 1'b0;
  beat_t stall_beat  = '0;
  int    drop_seen   = 0;
  int    beats_out   = 0;
  int    tready_mode = 0;  // 0 low, 1 high, 2 toggle

  function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Everything seen at a negedge describes what the next posedge will do.
  always @(negedge clk) begin : cmp
    beat_t out_b;
    beat_t e;
    out_b = {m_tlast, m_tkeep, m_tdata};
    chk("s_tready", 128'(s_tready), 128'(rst_seen));
    if (!rst_seen) begin
      chk("m_tvalid_in_reset", 128'(m_tvalid), 128'(0));
      chk("pkt_avail_in_reset", 128'(pkt_avail), 128'(0));
      chk("drop_pulse_in_reset", 128'(drop_pulse), 128'(0));
    end else begin
      chk("drop_pulse", 128'(drop_pulse), 128'(drop_pend));
      chk("pkt_avail", 128'(pkt_avail), 128'(pend_cnt != 0));
      if (prev_stall) begin
        chk("stall_valid", 128'(m_tvalid), 128'(1));
        chk("stall_stable", 128'(out_b), 128'(stall_beat));
      end else if (mid_frame) begin
        chk("mid_frame_valid", 128'(m_tvalid), 128'(1));
      end
    end
    if (drop_pulse === 1'b1) drop_seen++;
    drop_pend = 1'b0;
    if (!rst) begin
      exp_q.delete();
      cur_q.delete();
      pend_cnt  = 0;
      mid_frame = 1'b0;
    end else begin
      if (m_tvalid && m_tready) begin
        beats_out++;
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 128'(m_tvalid), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("beat", 128'(out_b), 128'(e));
          mid_frame = !e[LastBit];
          if (e[LastBit]) pend_cnt--;
        end
      end
      if (s_tvalid) begin
        cur_q.push_back({s_tlast, s_tkeep, s_tdata});
        if (s_tlast) begin
          if (frame_good) begin
            foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
            pend_cnt++;
          end else begin
            drop_pend = 1'b1;
          end
          cur_q.delete();
        end
      end
    end
    prev_stall = rst && m_tvalid && !m_tready;
    stall_beat = out_b;
    rst_seen   = rst;
  end

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        default: m_tready = ~m_tready;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int fid, input int len, input bit tuser, input bit good);
    frame_good = good;
    for (int i = 0; i < len; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = {32'(fid) + 32'hF0, 32'(i)};
      s_tlast  = (i == len - 1);
      s_tkeep  = (i == len - 1) ? (8'hFF >> (fid % 8)) : 8'hFF;
      s_tuser  = (i == len - 1) ? tuser : 1'b0;
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic drain_wait(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 128'(exp_q.size()), 128'(0));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst      = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();

    // Single good 4-beat frame, latency and pkt_avail pinned literally.
    tready_mode = 1;
    tick();
    send_frame(1, 4, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_avail_commit", 128'(pkt_avail), 128'(1));
    chk("t1_valid_c0", 128'(m_tvalid), 128'(0));
    @(negedge clk);
    chk("t1_valid_c1", 128'(m_tvalid), 128'(0));
    @(negedge clk);
    chk("t1_valid_c2", 128'(m_tvalid), 128'(1));
    chk("t1_first_data", 128'(m_tdata), 128'(64'h0000_00F1_0000_0000));
    chk("t1_first_keep", 128'(m_tkeep), 128'(8'hFF));
    drain_wait(50);
    chk("t1_avail_drained", 128'(pkt_avail), 128'(0));
    chk("t1_beats", 128'(beats_out), 128'(4));

    // Errored frame then good frame.
    send_frame(2, 3, 1'b1, 1'b0);
    send_frame(3, 2, 1'b0, 1'b1);
    drain_wait(50);
    chk("t2_drops", 128'(drop_seen), 128'(1));
    chk("t2_beats", 128'(beats_out), 128'(6));

    // Oversized frame while stalled, then a small frame that must survive.
    tready_mode = 0;
    repeat (2) tick();
    send_frame(4, 20, 1'b0, 1'b0);
    send_frame(5, 5, 1'b0, 1'b1);
    repeat (4) tick();
    chk("t3_drops", 128'(drop_seen), 128'(2));
    chk("t3_avail_held", 128'(pkt_avail), 128'(1));
    tready_mode = 1;
    drain_wait(80);
    chk("t3_beats", 128'(beats_out), 128'(11));

    // Three 8-beat frames under 1010 back-pressure.
    base = beats_out;
    tready_mode = 2;
    send_frame(6, 8, 1'b0, 1'b1);
    repeat (8) tick();
    send_frame(7, 8, 1'b0, 1'b1);
    repeat (8) tick();
    send_frame(8, 8, 1'b0, 1'b1);
    drain_wait(200);
    chk("t4_beats", 128'(beats_out - base), 128'(24));
    chk("t4_avail_zero", 128'(pkt_avail), 128'(0));

    // Back-to-back 1- and 7-beat frames across several pointer wraps.
    base = beats_out;
    tready_mode = 1;
    repeat (2) tick();
    for (int k = 0; k < 6; k++) begin
      send_frame(10 + 2 * k, 1, 1'b0, 1'b1);
      send_frame(11 + 2 * k, 7, 1'b0, 1'b1);
    end
    drain_wait(200);
    chk("t5_beats", 128'(beats_out - base), 128'(48));
    chk("t5_avail_zero", 128'(pkt_avail), 128'(0));

    // Reset during beat 2 of a 6-beat frame with one frame held.
    tready_mode = 0;
    repeat (2) tick();
    send_frame(30, 3, 1'b0, 1'b1);
    repeat (4) tick();
    frame_good = 1'b1;
    s_tvalid   = 1'b1;
    s_tlast    = 1'b0;
    s_tkeep    = 8'hFF;
    s_tdata    = {32'h110, 32'd0};
    tick();
    s_tdata = {32'h110, 32'd1};
    rst     = 1'b0;
    tick();
    rst      = 1'b1;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("t6_valid_after_rst", 128'(m_tvalid), 128'(0));
    chk("t6_ready_after_rst", 128'(s_tready), 128'(0));
    chk("t6_avail_after_rst", 128'(pkt_avail), 128'(0));
    tick();
    tick();
    base = beats_out;
    tready_mode = 1;
    send_frame(31, 6, 1'b0, 1'b1);
    drain_wait(80);
    chk("t6_beats", 128'(beats_out - base), 128'(6));
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
